// File: rtl/wbuf_seq.sv
// -----------------------------------------------------------------------------
// wbuf_seq -- W_buffer burst sequencer
//
// Purpose:
//   Walks a job of cfg_num_tiles tiles through the W_buffer.  Each tile is one
//   burst of ARRAY_N cycles with wb_on=1 at a fixed base address.  Between
//   tiles the sequencer waits (at least one cycle) for array_ready.  The base
//   address advances by cfg_stride per tile and wraps modulo 2^ADDR_WIDTH.
//   A job with zero tiles or zero columns completes immediately with a single
//   done pulse and no burst.  abort ends a job from any state.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-low
//   start          in   one-cycle job request, sampled only in IDLE
//   abort          in   terminate the current job (priority over everything)
//   cfg_mode       in   W_buffer mode for the whole job
//   cfg_base_addr  in   start address of tile 0
//   cfg_stride     in   address increment between tiles
//   cfg_num_tiles  in   number of tiles in the job
//   cfg_num_cols   in   active columns per tile (clamped to ARRAY_M)
//   array_ready    in   array can accept the next tile
//   wb_mode        out  W_buffer mode
//   wb_on          out  W_buffer on (high for the ARRAY_N cycles of a burst)
//   wb_base_addr   out  W_buffer base address of the current tile
//   wb_num_cols    out  W_buffer active column count
//   busy           out  high in every state other than IDLE
//   done           out  one-cycle completion pulse
//   tile_idx       out  index of the tile loading or last loaded
//
// All outputs are registers; every one is derived from the next-state values
// computed in a single combinational block.
// -----------------------------------------------------------------------------

// Property checker for the sequencer outputs; holds no design logic.
module wbuf_seq_chk #(
   parameter int ADDR_WIDTH = 8,
   parameter int ARRAY_M    = 8
) (
   input logic                      clk,
   input logic                      reset,
   input logic                      abort,
   input logic                      wb_mode,
   input logic                      wb_on,
   input logic [ADDR_WIDTH-1:0]     wb_base_addr,
   input logic [$clog2(ARRAY_M):0]  wb_num_cols,
   input logic                      busy,
   input logic                      done
);

   localparam int CW = $clog2(ARRAY_M) + 1;

   // done and a burst never overlap
   a_done_not_on: assert property (@(posedge clk) disable iff (!reset)
      done |-> !wb_on);

   // a burst only happens inside a job
   a_on_busy: assert property (@(posedge clk) disable iff (!reset)
      wb_on |-> busy);

   // done is a single-cycle pulse
   a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
      done |=> !done);

   // burst attributes stay fixed while a burst is running
   a_burst_stable: assert property (@(posedge clk) disable iff (!reset)
      (wb_on && $past(wb_on)) |->
         ($stable(wb_base_addr) && $stable(wb_num_cols) && $stable(wb_mode)));

   // column count never exceeds the array width
   a_cols_clamped: assert property (@(posedge clk) disable iff (!reset)
      wb_num_cols <= CW'(ARRAY_M));

   // abort during a job always lands in IDLE without completion
   a_abort_idle: assert property (@(posedge clk) disable iff (!reset)
      (abort && busy) |=> (!busy && !done && !wb_on));

endmodule

module wbuf_seq #(
   parameter int RAM_SIZE   = 256,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int ARRAY_N    = 8,
   parameter int ARRAY_M    = 8,
   parameter int TILE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      cfg_mode,
   input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]     cfg_stride,
   input  logic [TILE_WIDTH-1:0]     cfg_num_tiles,
   input  logic [$clog2(ARRAY_M):0]  cfg_num_cols,
   input  logic                      array_ready,
   output logic                      wb_mode,
   output logic                      wb_on,
   output logic [ADDR_WIDTH-1:0]     wb_base_addr,
   output logic [$clog2(ARRAY_M):0]  wb_num_cols,
   output logic                      busy,
   output logic                      done,
   output logic [TILE_WIDTH-1:0]     tile_idx
);

   localparam int CW     = $clog2(ARRAY_M) + 1;
   localparam int BEAT_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ARRAY_N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   // Column count requested beyond the array width is limited to the width.
   function automatic logic [CW-1:0] clamp_cols(input logic [CW-1:0] cols);
      logic [CW-1:0] res;
      if (cols > CW'(ARRAY_M)) begin
         res = CW'(ARRAY_M);
      end else begin
         res = cols;
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [1:0]            state_r;
   logic [BEAT_W-1:0]     beat_r;
   logic [ADDR_WIDTH-1:0] stride_r;
   logic [TILE_WIDTH-1:0] num_tiles_r;

   // ---------------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------------
   logic [1:0]            state_s;
   logic [BEAT_W-1:0]     beat_s;
   logic [ADDR_WIDTH-1:0] stride_s;
   logic [TILE_WIDTH-1:0] num_tiles_s;
   logic [TILE_WIDTH-1:0] tile_idx_s;
   logic [ADDR_WIDTH-1:0] base_addr_s;
   logic                  mode_s;
   logic [CW-1:0]         num_cols_s;
   logic                  degenerate_s;
   logic                  last_beat_s;
   logic                  last_tile_s;

   // Job decode helpers used by the transition logic.
   always_comb begin
      degenerate_s = (cfg_num_tiles == TILE_WIDTH'(0)) || (cfg_num_cols == CW'(0));
      last_beat_s  = (beat_r == BEAT_LAST);
      // num_tiles_r is at least 1 whenever a burst is running
      last_tile_s  = (tile_idx == (num_tiles_r - TILE_WIDTH'(1)));
   end

   // State transitions and next values of the job registers.
   always_comb begin
      state_s     = state_r;
      beat_s      = beat_r;
      stride_s    = stride_r;
      num_tiles_s = num_tiles_r;
      tile_idx_s  = tile_idx;
      base_addr_s = wb_base_addr;
      mode_s      = wb_mode;
      num_cols_s  = wb_num_cols;

      case (state_r)
         ST_IDLE: begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
               stride_s    = cfg_stride;
               num_tiles_s = cfg_num_tiles;
               if (degenerate_s) begin
                  // nothing to load: W_buffer attributes keep their old values
                  state_s = ST_FIN;
               end else begin
                  state_s     = ST_LOAD;
                  beat_s      = BEAT_W'(0);
                  tile_idx_s  = TILE_WIDTH'(0);
                  base_addr_s = cfg_base_addr;
                  mode_s      = cfg_mode;
                  num_cols_s  = clamp_cols(cfg_num_cols);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_LOAD: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (last_beat_s) begin
               if (last_tile_s) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_WAIT;
               end
            end else begin
               beat_s = beat_r + BEAT_W'(1);
            end
         end

         ST_WAIT: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (array_ready) begin
               state_s     = ST_LOAD;
               beat_s      = BEAT_W'(0);
               tile_idx_s  = tile_idx + TILE_WIDTH'(1);
               // address wraps silently at the top of the buffer
               base_addr_s = wb_base_addr + stride_r;
            end else begin
               state_s = ST_WAIT;
            end
         end

         ST_FIN: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, job registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         beat_r       <= BEAT_W'(0);
         stride_r     <= ADDR_WIDTH'(0);
         num_tiles_r  <= TILE_WIDTH'(0);
         tile_idx     <= TILE_WIDTH'(0);
         wb_base_addr <= ADDR_WIDTH'(0);
         wb_mode      <= 1'b0;
         wb_num_cols  <= CW'(0);
         wb_on        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r      <= state_s;
         beat_r       <= beat_s;
         stride_r     <= stride_s;
         num_tiles_r  <= num_tiles_s;
         tile_idx     <= tile_idx_s;
         wb_base_addr <= base_addr_s;
         wb_mode      <= mode_s;
         wb_num_cols  <= num_cols_s;
         // status outputs reflect the state being entered
         wb_on        <= (state_s == ST_LOAD);
         busy         <= (state_s != ST_IDLE);
         done         <= (state_s == ST_FIN);
      end
   end

   wbuf_seq_chk #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ARRAY_M    (ARRAY_M)
   ) u_chk (
      .clk          (clk),
      .reset        (reset),
      .abort        (abort),
      .wb_mode      (wb_mode),
      .wb_on        (wb_on),
      .wb_base_addr (wb_base_addr),
      .wb_num_cols  (wb_num_cols),
      .busy         (busy),
      .done         (done)
   );

endmodule

// File: tb/tb_wbuf_seq.sv
// -----------------------------------------------------------------------------
// tb_wbuf_seq -- directed bench for wbuf_seq (ARRAY_N=8, ARRAY_M=8, 8-bit
// addresses and tile counter). Job records carry hand-computed burst
// addresses, column counts and modes; the cycle timeline of each job
// (8-cycle bursts, chosen gap, done cycle) is derived from the record.
// Inputs change on the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_wbuf_seq;

   localparam int AW = 8;
   localparam int TW = 8;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic          cfg_mode;
   logic [AW-1:0] cfg_base_addr;
   logic [AW-1:0] cfg_stride;
   logic [TW-1:0] cfg_num_tiles;
   logic [CW-1:0] cfg_num_cols;
   logic          array_ready;
   logic          wb_mode;
   logic          wb_on;
   logic [AW-1:0] wb_base_addr;
   logic [CW-1:0] wb_num_cols;
   logic          busy;
   logic          done;
   logic [TW-1:0] tile_idx;

   wbuf_seq #(
      .RAM_SIZE   (256),
      .ARRAY_N    (8),
      .ARRAY_M    (8),
      .TILE_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_mode      (cfg_mode),
      .cfg_base_addr (cfg_base_addr),
      .cfg_stride    (cfg_stride),
      .cfg_num_tiles (cfg_num_tiles),
      .cfg_num_cols  (cfg_num_cols),
      .array_ready   (array_ready),
      .wb_mode       (wb_mode),
      .wb_on         (wb_on),
      .wb_base_addr  (wb_base_addr),
      .wb_num_cols   (wb_num_cols),
      .busy          (busy),
      .done          (done),
      .tile_idx      (tile_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          mode;
      logic [AW-1:0] base;
      logic [AW-1:0] stride;
      logic [TW-1:0] tiles;
      logic [CW-1:0] cols;
      int            gap;     // wait cycles between bursts
      logic          degen;   // zero tiles or zero columns
      logic [AW-1:0] ea0;     // expected address of tile 0 (held value if degen)
      logic [AW-1:0] ea1;
      logic [AW-1:0] ea2;
      logic [CW-1:0] ecols;
      logic          emode;
   } job_t;

   job_t jobs [6];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input int cyc,
                      input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " wb_on"},    0, 32'(wb_on),        32'd0);
      chk({nm, " wb_mode"},  0, 32'(wb_mode),      32'd0);
      chk({nm, " busy"},     0, 32'(busy),         32'd0);
      chk({nm, " done"},     0, 32'(done),         32'd0);
      chk({nm, " base"},     0, 32'(wb_base_addr), 32'd0);
      chk({nm, " cols"},     0, 32'(wb_num_cols),  32'd0);
      chk({nm, " tile_idx"}, 0, 32'(tile_idx),     32'd0);
   endtask

   // Start a job in cycle 0 and check every output through the idle cycle
   // after done. A second start and scrambled cfg inputs are applied mid-job.
   task automatic run_job(input job_t j);
      int            n, p, d, k, r;
      logic [AW-1:0] ea [3];
      logic          exp_on;
      ea[0] = j.ea0;
      ea[1] = j.ea1;
      ea[2] = j.ea2;
      n = j.degen ? 0 : int'(j.tiles);
      p = 8 + j.gap;
      d = j.degen ? 1 : 1 + n * 8 + (n - 1) * j.gap;

      @(negedge clk);
      cfg_mode      = j.mode;
      cfg_base_addr = j.base;
      cfg_stride    = j.stride;
      cfg_num_tiles = j.tiles;
      cfg_num_cols  = j.cols;
      start         = 1'b1;
      abort         = 1'b0;
      array_ready   = 1'b0;

      for (int c = 1; c <= d + 1; c++) begin
         @(negedge clk);
         start = (!j.degen && c == 3);
         if (c == 1) begin
            cfg_mode      = ~j.mode;
            cfg_base_addr = ~j.base;
            cfg_stride    = ~j.stride;
            cfg_num_tiles = j.tiles + 8'd1;
            cfg_num_cols  = j.cols ^ 4'h3;
         end
         k = (c - 1) / p;
         r = (c - 1) % p;
         exp_on = !j.degen && (c < d) && (r < 8);
         if (j.degen) begin
            k = 0;
         end else if (c >= d) begin
            k = n - 1;
         end
         // release the array only in the last planned wait cycle
         array_ready = !j.degen && (c < d) && (r >= 8) && ((r - 8 + 1) == j.gap);

         chk("wb_on", c, 32'(wb_on),        32'(exp_on));
         chk("busy",  c, 32'(busy),         32'(c <= d));
         chk("done",  c, 32'(done),         32'(c == d));
         chk("mode",  c, 32'(wb_mode),      32'(j.emode));
         chk("cols",  c, 32'(wb_num_cols),  32'(j.ecols));
         chk("base",  c, 32'(wb_base_addr), 32'(ea[k]));
         if (!j.degen) begin
            chk("tile_idx", c, 32'(tile_idx), 32'(k));
         end
      end
      start       = 1'b0;
      array_ready = 1'b0;
   endtask

   initial begin
      // single tile, full columns
      jobs[0] = '{mode:1'b1, base:8'h00, stride:8'h00, tiles:8'd1, cols:4'd8, gap:1,
                  degen:1'b0, ea0:8'h00, ea1:8'h00, ea2:8'h00, ecols:4'd8, emode:1'b1};
      // three tiles with a 3-cycle gap between bursts
      jobs[1] = '{mode:1'b0, base:8'h10, stride:8'h20, tiles:8'd3, cols:4'd5, gap:3,
                  degen:1'b0, ea0:8'h10, ea1:8'h30, ea2:8'h50, ecols:4'd5, emode:1'b0};
      // address wrap 0xF0 -> 0x10, 12 columns clamped to 8
      jobs[2] = '{mode:1'b1, base:8'hF0, stride:8'h20, tiles:8'd2, cols:4'd12, gap:1,
                  degen:1'b0, ea0:8'hF0, ea1:8'h10, ea2:8'h00, ecols:4'd8, emode:1'b1};
      // zero tiles: outputs hold the previous job's last values
      jobs[3] = '{mode:1'b0, base:8'h77, stride:8'h01, tiles:8'd0, cols:4'd4, gap:1,
                  degen:1'b1, ea0:8'h10, ea1:8'h00, ea2:8'h00, ecols:4'd8, emode:1'b1};
      // zero columns: same response
      jobs[4] = '{mode:1'b0, base:8'h55, stride:8'h01, tiles:8'd3, cols:4'd0, gap:1,
                  degen:1'b1, ea0:8'h10, ea1:8'h00, ea2:8'h00, ecols:4'd8, emode:1'b1};
      // two tiles, small stride, gap of 2
      jobs[5] = '{mode:1'b0, base:8'h40, stride:8'h08, tiles:8'd2, cols:4'd3, gap:2,
                  degen:1'b0, ea0:8'h40, ea1:8'h48, ea2:8'h00, ecols:4'd3, emode:1'b0};

      reset         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      cfg_mode      = 1'b1;
      cfg_base_addr = 8'hAA;
      cfg_stride    = 8'h11;
      cfg_num_tiles = 8'd2;
      cfg_num_cols  = 4'd5;
      array_ready   = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_job(jobs[i]);
      end

      // abort in the 4th LOAD cycle
      @(negedge clk);
      cfg_mode = 1'b1; cfg_base_addr = 8'h20; cfg_stride = 8'h10;
      cfg_num_tiles = 8'd2; cfg_num_cols = 4'd6; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (c == 4);
         chk("abort wb_on", c, 32'(wb_on),        32'd1);
         chk("abort base",  c, 32'(wb_base_addr), 32'h20);
      end
      @(negedge clk);
      abort = 1'b0;
      chk("abort wb_on after", 5, 32'(wb_on),        32'd0);
      chk("abort busy after",  5, 32'(busy),         32'd0);
      chk("abort done after",  5, 32'(done),         32'd0);
      chk("abort base hold",   5, 32'(wb_base_addr), 32'h20);
      for (int c = 6; c <= 10; c++) begin
         @(negedge clk);
         chk("abort no done", c, 32'(done),  32'd0);
         chk("abort no on",   c, 32'(wb_on), 32'd0);
      end

      // start and abort together in IDLE: stay idle
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         chk("start+abort busy",  c, 32'(busy),  32'd0);
         chk("start+abort wb_on", c, 32'(wb_on), 32'd0);
      end

      // reset in the 4th LOAD cycle
      @(negedge clk);
      cfg_mode = 1'b1; cfg_base_addr = 8'h99; cfg_stride = 8'h01;
      cfg_num_tiles = 8'd1; cfg_num_cols = 4'd7; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 4) begin
            reset = 1'b0;
         end
         chk("pre-reset wb_on", c, 32'(wb_on), 32'd1);
      end
      @(negedge clk);
      reset = 1'b1;
      chk_all_zero("mid-job reset");
      for (int c = 6; c <= 12; c++) begin
         @(negedge clk);
         chk("reset no done", c, 32'(done),  32'd0);
         chk("reset no on",   c, 32'(wb_on), 32'd0);
      end

      // first job after reset behaves like the single-tile case
      run_job(jobs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
